// File: rtl/fir_output_checker.sv
// Output checker for the three FIR instances: compares two DUT outputs to the golden reference.
// Optional FIR_CHK_STOP_ON_FAIL_EN ends the run at the first mismatch.
module fir_output_checker #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 16,
   parameter int SKIP  = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] num_samples,
   input  logic             sample_valid,
   input  logic [WIDTH-1:0] y_ref,
   input  logic [WIDTH-1:0] y_dut0,
   input  logic [WIDTH-1:0] y_dut1,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] mismatch_count,
   output logic [1:0]       fail_mask,
   output logic [CNT_W-1:0] fail_index,
   output logic [WIDTH-1:0] fail_ref
);

   localparam int SK_W    = (SKIP > 1) ? $clog2(SKIP) : 1;
   localparam int SKIP_M1 = (SKIP > 0) ? SKIP - 1 : 0;

   typedef enum logic [1:0] {IDLE, FLUSH, CHECK, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] n_lat;
   logic [CNT_W-1:0] idx;
   logic [SK_W-1:0]  skip_cnt;
   logic [1:0]       mask_now;
   logic             mis;
   logic             last;

   always_comb begin
      mask_now = {y_dut1 != y_ref, y_dut0 != y_ref};
      mis      = |mask_now;
      last     = (idx == n_lat - CNT_W'(1));
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= IDLE;
         n_lat          <= '0;
         idx            <= '0;
         skip_cnt       <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         mismatch_count <= '0;
         fail_mask      <= '0;
         fail_index     <= '0;
         fail_ref       <= '0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  n_lat          <= num_samples;
                  idx            <= '0;
                  skip_cnt       <= '0;
                  done           <= 1'b0;
                  pass           <= 1'b0;
                  mismatch_count <= '0;
                  fail_mask      <= '0;
                  fail_index     <= '0;
                  fail_ref       <= '0;
                  if (SKIP > 0) begin
                     state <= FLUSH;
                     busy  <= 1'b1;
                  end else if (num_samples == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                     pass  <= 1'b1;
                  end else begin
                     state <= CHECK;
                     busy  <= 1'b1;
                  end
               end
            end
            FLUSH: begin
               if (sample_valid) begin
                  if (skip_cnt == SK_W'(SKIP_M1)) begin
                     skip_cnt <= '0;
                     if (n_lat == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                     end else begin
                        state <= CHECK;
                     end
                  end else begin
                     skip_cnt <= skip_cnt + SK_W'(1);
                  end
               end
            end
            CHECK: begin
               if (sample_valid) begin
                  idx <= idx + CNT_W'(1);
                  if (mis) begin
                     if (mismatch_count != '1)
                        mismatch_count <= mismatch_count + CNT_W'(1);
                     // zero count means this is the first failure of the run
                     if (mismatch_count == '0) begin
                        fail_mask  <= mask_now;
                        fail_index <= idx;
                        fail_ref   <= y_ref;
                     end
                  end
`ifdef FIR_CHK_STOP_ON_FAIL_EN
                  if (mis || last) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= !mis && (mismatch_count == '0);
                  end
`else
                  if (last) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= !mis && (mismatch_count == '0);
                  end
`endif
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fir_output_checker.sv
// Randomized self-checking bench for fir_output_checker.
// Reference results are computed from the captured sample arrays.
module tb_fir_output_checker;

   localparam int W    = 16;
   localparam int CW   = 16;
   localparam int SKIP = 8;

   logic          clk = 0;
   logic          reset = 0;
   logic          start = 0;
   logic [CW-1:0] num_samples = 0;
   logic          sample_valid = 0;
   logic [W-1:0]  y_ref = 0, y_dut0 = 0, y_dut1 = 0;
   logic          busy, done, pass;
   logic [CW-1:0] mismatch_count, fail_index;
   logic [1:0]    fail_mask;
   logic [W-1:0]  fail_ref;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] ra [256];
   logic [W-1:0] d0a[256];
   logic [W-1:0] d1a[256];

   fir_output_checker #(.WIDTH(W), .CNT_W(CW), .SKIP(SKIP)) dut (
      .clk(clk), .reset(reset), .start(start), .num_samples(num_samples),
      .sample_valid(sample_valid), .y_ref(y_ref), .y_dut0(y_dut0),
      .y_dut1(y_dut1), .busy(busy), .done(done), .pass(pass),
      .mismatch_count(mismatch_count), .fail_mask(fail_mask),
      .fail_index(fail_index), .fail_ref(fail_ref)
   );

   always #5 clk = ~clk;

   task automatic fill(input int total);
      for (int i = 0; i < total; i++) begin
         ra[i]  = W'($urandom);
         d0a[i] = ra[i];
         d1a[i] = ra[i];
      end
   endtask

   task automatic check_zero(input string name);
      checks++;
      if ({busy, done, pass} !== 3'b000 || mismatch_count !== 0 ||
          fail_mask !== 0 || fail_index !== 0 || fail_ref !== 0) begin
         errors++;
         $display("FAIL %s outputs got b%0d d%0d p%0d c%0d m%0d i%0d r%0d want all 0",
                  name, busy, done, pass, mismatch_count, fail_mask,
                  fail_index, fail_ref);
      end
   endtask

   task automatic test_reset();
      reset = 0;
      repeat (2) @(negedge clk);
      reset = 1;
      @(negedge clk);
      check_zero("reset");
   endtask

   task automatic run_case(input string name, input int n, input int gap,
                           input bit poke);
      int total, rise, cnt, first, exp_rise;
      logic [1:0] emask;
      logic [W-1:0] eref;
      total = SKIP + n;
      cnt = 0; first = -1; emask = 0; eref = 0;
      for (int p = SKIP; p < total; p++) begin
         if (d0a[p] != ra[p] || d1a[p] != ra[p]) begin
            if (first < 0) begin
               first = p - SKIP;
               emask = {d1a[p] != ra[p], d0a[p] != ra[p]};
               eref  = ra[p];
            end
            cnt++;
         end
      end
      exp_rise = total;
`ifdef FIR_CHK_STOP_ON_FAIL_EN
      if (first >= 0) begin
         exp_rise = SKIP + first + 1;
         cnt = 1;
      end
`endif
      // start cycle carries a bad sample that must not be consumed
      @(negedge clk);
      start = 1; num_samples = CW'(n);
      sample_valid = 1; y_ref = 16'h1234; y_dut0 = 16'h4321; y_dut1 = 16'h1234;
      @(negedge clk);
      start = 0; sample_valid = 0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL %s start busy=%0d done=%0d want 1 0", name, busy, done);
      end
      rise = -1;
      for (int p = 0; p < total; p++) begin
         for (int g = 0; g < gap; g++) begin
            sample_valid = 0;
            @(negedge clk);
            if (done && rise == -1) rise = -2;
         end
         sample_valid = 1;
         y_ref = ra[p]; y_dut0 = d0a[p]; y_dut1 = d1a[p];
         if (poke && p == 20) begin
            start = 1; num_samples = 3;
         end
         @(negedge clk);
         start = 0;
         if (done && rise == -1) rise = p + 1;
      end
      sample_valid = 0;
      for (int k = 0; k < 5 && rise == -1; k++) begin
         @(negedge clk);
         if (done) rise = -2;
      end
      checks++;
      if (rise != exp_rise) begin
         errors++;
         $display("FAIL %s done_timing got %0d want %0d", name, rise, exp_rise);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || pass !== (cnt == 0)) begin
         errors++;
         $display("FAIL %s status got d%0d b%0d p%0d want d1 b0 p%0d",
                  name, done, busy, pass, cnt == 0);
      end
      checks++;
      if (mismatch_count !== CW'(cnt)) begin
         errors++;
         $display("FAIL %s count got %0d want %0d", name, mismatch_count, cnt);
      end
      checks++;
      if (fail_mask !== emask || fail_index !== CW'(first < 0 ? 0 : first) ||
          fail_ref !== eref) begin
         errors++;
         $display("FAIL %s capture got m%0d i%0d r%0d want m%0d i%0d r%0d",
                  name, fail_mask, fail_index, fail_ref, emask,
                  first < 0 ? 0 : first, eref);
      end
   endtask

   task automatic test_all_equal();
      fill(SKIP + 100);
      run_case("all_equal", 100, 0, 0);
   endtask

   task automatic test_dut1_mismatch();
      fill(SKIP + 100);
      foreach (ra[i]) if (i == SKIP + 5 || i == SKIP + 40) begin
         ra[i] = 10000; d0a[i] = 10000; d1a[i] = 9999;
      end
      run_case("dut1_mis", 100, 0, 0);
   endtask

   task automatic test_skip_mismatch();
      fill(SKIP + 100);
      for (int i = 0; i < SKIP; i++) d0a[i] = ~ra[i];
      run_case("skip_mis", 100, 0, 0);
      run_case("skip_mis_gap", 100, 3, 0);
   endtask

   task automatic test_zero_samples();
      fill(SKIP);
      for (int i = 0; i < SKIP; i++) d1a[i] = ra[i] + 1;
      run_case("zero_n", 0, 0, 0);
   endtask

   task automatic test_busy_start();
      fill(SKIP + 52);
      run_case("busy_start", 52, 1, 1);
   endtask

   task automatic test_reset_mid();
      fill(SKIP + 100);
      d0a[SKIP + 10] = ~ra[SKIP + 10];
      @(negedge clk);
      start = 1; num_samples = 100;
      @(negedge clk);
      start = 0;
      for (int p = 0; p < SKIP + 50; p++) begin
         sample_valid = 1;
         y_ref = ra[p]; y_dut0 = d0a[p]; y_dut1 = d1a[p];
         @(negedge clk);
      end
      sample_valid = 0;
      reset = 0;
      @(negedge clk);
      reset = 1;
      check_zero("reset_mid");
      fill(SKIP + 60);
      run_case("after_reset", 60, 0, 0);
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         int n;
         n = $urandom_range(60, 1);
         fill(SKIP + n);
         for (int i = 0; i < SKIP + n; i++) begin
            if ($urandom_range(7, 0) == 0) d0a[i] = ra[i] ^ 16'h0100;
            if ($urandom_range(7, 0) == 0) d1a[i] = ra[i] ^ 16'h8000;
         end
         run_case("random", n, $urandom_range(2, 0), 0);
      end
   endtask

   initial begin
      test_reset();
      test_all_equal();
      test_dut1_mismatch();
      test_skip_mismatch();
      test_zero_samples();
      test_busy_start();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
